// File: rtl/wb_stage.sv
// Writeback stage: mem->wb pipeline register, result select, register-file write port,
// and serial byte collection. Define WB_RETIRE_CNT_EN to add the 64-bit retired_cnt output.
module wb_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned SRC_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              flush_m,
    input  logic              reg_write_m,
    input  logic [SRC_W-1:0]  result_src_m,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [DATA_W-1:0] read_data_m,
    input  logic [DATA_W-1:0] pc_plus4_m,
    input  logic [DATA_W-1:0] c_reg_data_out_m,
    input  logic [DATA_W-1:0] result_bytes_m,
    input  logic [4:0]        rd_m,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              stall_wb,
    output logic              busy
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retired_cnt
`endif
);

    localparam int unsigned CNT_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned NB_W  = 3;

    localparam logic [SRC_W-1:0] SRC_ALU  = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_MEM  = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_PC4  = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_CREG = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRC_SER  = SRC_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [SRC_W-1:0]  src;
        logic [NB_W-1:0]   nbytes;
        logic [4:0]        rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] creg;
    } slot_t;

    state_t            state;
    slot_t             slot;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;

    logic              ser_slot;
    logic              commit;
    logic              last_byte;
    logic [NB_W-1:0]   n_raw;
    logic [NB_W-1:0]   n_norm;
    logic [SRC_W-1:0]  src_norm;
    logic [DATA_W-1:0] sel_data;
    logic              unused_bytes_hi;

    // Only the low three bits of the byte-count field carry information.
    assign unused_bytes_hi = ^result_bytes_m[DATA_W-1:NB_W];

    // Byte count: 0 means one byte, anything above MAX_BYTES saturates.
    assign n_raw  = result_bytes_m[NB_W-1:0];
    assign n_norm = (n_raw == NB_W'(0))         ? NB_W'(1) :
                    (n_raw > NB_W'(MAX_BYTES))  ? NB_W'(MAX_BYTES) : n_raw;

    // Reserved source encodings fall back to the ALU result.
    assign src_norm = (result_src_m > SRC_SER) ? SRC_ALU : result_src_m;

    assign ser_slot  = slot.valid && (slot.src == SRC_SER);
    assign last_byte = (NB_W'(cnt) == (slot.nbytes - NB_W'(1)));

    assign stall_wb = ((state == ST_IDLE) && ser_slot) || (state == ST_COLLECT);
    assign in_ready = (state == ST_COLLECT);
    assign busy     = (state == ST_COLLECT);

    assign commit = ((state == ST_IDLE) && slot.valid && !ser_slot) || (state == ST_COMMIT);

    always_comb begin
        sel_data = slot.alu;
        case (slot.src)
            SRC_MEM:  sel_data = slot.mem;
            SRC_PC4:  sel_data = slot.pc4;
            SRC_CREG: sel_data = slot.creg;
            SRC_SER:  sel_data = acc;
            default:  sel_data = slot.alu;
        endcase
    end

    assign rf_we = commit && slot.reg_write && (slot.rd != 5'd0);
    assign rf_wa = slot.rd;
    assign rf_wd = (state == ST_COMMIT) ? acc : sel_data;

    // Pipeline slot, collection FSM and byte accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            slot  <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            if (!stall_wb) begin
                slot.valid     <= valid_m && !flush_m;
                slot.reg_write <= reg_write_m;
                slot.src       <= src_norm;
                slot.nbytes    <= n_norm;
                slot.rd        <= rd_m;
                slot.alu       <= alu_result_m;
                slot.mem       <= read_data_m;
                slot.pc4       <= pc_plus4_m;
                slot.creg      <= c_reg_data_out_m;
            end
            case (state)
                ST_IDLE: begin
                    if (ser_slot) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        acc[{cnt, 3'b000} +: 8] <= in_data;
                        cnt                     <= cnt + CNT_W'(1);
                        if (last_byte) begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    acc   <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Retired-instruction counter; wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (commit) begin
            retired_cnt <= retired_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected register-file writes
// plus per-scenario checks on stall, handshake and reset behaviour.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m, flush_m, reg_write_m;
    logic [2:0]  result_src_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m, c_reg_data_out_m, result_bytes_m;
    logic [4:0]  rd_m;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, rf_we, stall_wb, busy;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_cnt;
`endif

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          hs = 0;
    longint unsigned exp_ret = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .flush_m(flush_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .pc_plus4_m(pc_plus4_m), .c_reg_data_out_m(c_reg_data_out_m),
        .result_bytes_m(result_bytes_m), .rd_m(rd_m),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .stall_wb(stall_wb), .busy(busy)
`ifdef WB_RETIRE_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    // Write monitor: every register-file write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_we) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write wa=%0d wd=%h required no write", rf_wa, rf_wd);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (rf_wa !== e.wa || rf_wd !== e.wd) begin
                        errors++;
                        $display("FAIL write wa=%0d wd=%h required wa=%0d wd=%h", rf_wa, rf_wd, e.wa, e.wd);
                    end
                end
            end
            if (in_valid && in_ready) hs++;
        end
    end

    function automatic logic [31:0] exp_src(input logic [2:0] s, input logic [31:0] v);
        case (s)
            3'd1:    return ~v;
            3'd2:    return v + 32'd4;
            3'd3:    return {v[15:0], v[31:16]};
            default: return v;
        endcase
    endfunction

    task automatic clear_inputs();
        valid_m = 1'b0; flush_m = 1'b0; reg_write_m = 1'b0; result_src_m = 3'd0;
        alu_result_m = '0; read_data_m = '0; pc_plus4_m = '0; c_reg_data_out_m = '0;
        result_bytes_m = '0; rd_m = 5'd0; in_valid = 1'b0; in_data = 8'd0;
    endtask

    task automatic set_m(input logic fl, input logic rw, input logic [2:0] src,
                         input logic [31:0] v, input logic [31:0] nb, input logic [4:0] rd);
        valid_m = 1'b1; flush_m = fl; reg_write_m = rw; result_src_m = src;
        alu_result_m = v; read_data_m = ~v; pc_plus4_m = v + 32'd4;
        c_reg_data_out_m = {v[15:0], v[31:16]}; result_bytes_m = nb; rd_m = rd;
    endtask

    // Present one instruction for a single capture edge (caller ensures no stall).
    task automatic present(input logic fl, input logic rw, input logic [2:0] src,
                           input logic [31:0] v, input logic [31:0] nb, input logic [4:0] rd);
        set_m(fl, rw, src, v, nb, rd);
        @(posedge clk); #1;
        valid_m = 1'b0; flush_m = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b);
        int k;
        k = 0;
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL feed_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rf_we, rf_wa, rf_wd, in_ready, stall_wb, busy} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs we=%b wa=%0d wd=%h rdy=%b stall=%b busy=%b required all 0",
                     rf_we, rf_wa, rf_wd, in_ready, stall_wb, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        sb.push_back('{wa: 5'd5, wd: 32'h0000_1234});
        present(1'b0, 1'b1, 3'd0, 32'h0000_1234, 32'd1, 5'd5);
        exp_ret++;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || stall_wb !== 1'b0) begin
            errors++;
            $display("FAIL alu_write we=%b stall=%b required we=1 stall=0", rf_we, stall_wb);
        end
        settle();
    endtask

    task automatic test_x0();
        present(1'b0, 1'b1, 3'd0, 32'h0000_1234, 32'd1, 5'd0);
        exp_ret++;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL x0_write we=%b required 0", rf_we);
        end
        settle();
    endtask

    task automatic test_sources();
        for (int s = 0; s < 8; s++) begin
            if (s != 4) begin
                logic [31:0] v;
                v = 32'hA5C3_0000 | 32'(s * 16'h0101);
                sb.push_back('{wa: 5'(s + 1), wd: exp_src(3'(s), v)});
                present(1'b0, 1'b1, 3'(s), v, 32'd1, 5'(s + 1));
                exp_ret++;
            end
        end
        settle();
    endtask

    task automatic test_flush();
        present(1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'd1, 5'd3);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble we=%b required 0", rf_we);
        end
        settle();
`ifdef WB_RETIRE_CNT_EN
        checks++;
        if (retired_cnt !== 64'(exp_ret)) begin
            errors++;
            $display("FAIL flush_retired cnt=%0d required %0d", retired_cnt, exp_ret);
        end
`endif
    endtask

    task automatic test_serial4();
        int hs0;
        hs0 = hs;
        sb.push_back('{wa: 5'd10, wd: 32'h1234_5678});
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd4, 5'd10);
        @(negedge clk);
        checks++;
        if (stall_wb !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL serial_capture stall=%b we=%b required stall=1 we=0", stall_wb, rf_we);
        end
        feed_byte(8'h78);
        feed_byte(8'h56);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (stall_wb !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL serial_gap stall=%b busy=%b rdy=%b required 1 1 1", stall_wb, busy, in_ready);
            end
            @(posedge clk); #1;
        end
        feed_byte(8'h34);
        feed_byte(8'h12);
        @(negedge clk);
        checks++;
        if (stall_wb !== 1'b0 || in_ready !== 1'b0 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL serial_commit stall=%b rdy=%b we=%b required 0 0 1", stall_wb, in_ready, rf_we);
        end
        settle();
        exp_ret++;
        checks++;
        if (hs - hs0 !== 4) begin
            errors++;
            $display("FAIL serial4_handshakes got=%0d required 4", hs - hs0);
        end
    endtask

    task automatic test_serial_counts();
        int hs0;
        hs0 = hs;
        sb.push_back('{wa: 5'd6, wd: 32'h0000_00AB});
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd0, 5'd6);
        feed_byte(8'hAB);
        settle();
        exp_ret++;
        checks++;
        if (hs - hs0 !== 1) begin
            errors++;
            $display("FAIL count0_handshakes got=%0d required 1", hs - hs0);
        end
        hs0 = hs;
        sb.push_back('{wa: 5'd7, wd: 32'h4433_2211});
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd7, 5'd7);
        feed_byte(8'h11);
        feed_byte(8'h22);
        feed_byte(8'h33);
        feed_byte(8'h44);
        in_valid = 1'b1; in_data = 8'hEE;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_ret++;
        checks++;
        if (hs - hs0 !== 4) begin
            errors++;
            $display("FAIL count7_handshakes got=%0d required 4", hs - hs0);
        end
        hs0 = hs;
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd2, 5'd0);
        feed_byte(8'h01);
        feed_byte(8'h02);
        settle();
        present(1'b0, 1'b0, 3'd4, 32'h0, 32'd1, 5'd5);
        feed_byte(8'h03);
        settle();
        exp_ret += 2;
        checks++;
        if (hs - hs0 !== 3) begin
            errors++;
            $display("FAIL nowrite_handshakes got=%0d required 3", hs - hs0);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{wa: 5'd11, wd: 32'h0000_005A});
        sb.push_back('{wa: 5'd12, wd: 32'h0000_0201});
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd1, 5'd11);
        set_m(1'b0, 1'b1, 3'd4, 32'h0, 32'd2, 5'd12);
        feed_byte(8'h5A);
        @(negedge clk);
        checks++;
        if (stall_wb !== 1'b0) begin
            errors++;
            $display("FAIL b2b_commit stall=%b required 0", stall_wb);
        end
        @(posedge clk); #1;
        valid_m = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_wb !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_capture stall=%b required 1", stall_wb);
        end
        feed_byte(8'h01);
        feed_byte(8'h02);
        settle();
        exp_ret += 2;
    endtask

    task automatic test_flush_collect();
        sb.push_back('{wa: 5'd14, wd: 32'h0000_BBAA});
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd2, 5'd14);
        set_m(1'b1, 1'b1, 3'd0, 32'h0000_0077, 32'd1, 5'd7);
        feed_byte(8'hAA);
        feed_byte(8'hBB);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || stall_wb !== 1'b0) begin
            errors++;
            $display("FAIL flush_collect_commit we=%b stall=%b required 1 0", rf_we, stall_wb);
        end
        @(posedge clk); #1;
        valid_m = 1'b0; flush_m = 1'b0;
        exp_ret++;
        settle();
    endtask

    task automatic test_reset_mid();
        present(1'b0, 1'b1, 3'd4, 32'h0, 32'd4, 5'd9);
        feed_byte(8'hC1);
        feed_byte(8'hC2);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({rf_we, rf_wa, rf_wd, in_ready, stall_wb, busy} !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid we=%b wa=%0d wd=%h rdy=%b stall=%b busy=%b required all 0",
                     rf_we, rf_wa, rf_wd, in_ready, stall_wb, busy);
        end
        exp_ret = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'hC3;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_x0();
        test_sources();
        test_flush();
        test_serial4();
        test_serial_counts();
        test_back_to_back();
        test_flush_collect();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL missing_writes pending=%0d required 0", sb.size());
        end
`ifdef WB_RETIRE_CNT_EN
        checks++;
        if (retired_cnt !== 64'(exp_ret)) begin
            errors++;
            $display("FAIL final_retired cnt=%0d required %0d", retired_cnt, exp_ret);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
